cur_fetch_ctrl: RTL and testbench

Frame-level scheduler for the current-block double buffer in the motion-estimation datapath. It walks a frame in raster order of 8x8 blocks, issues 16 word reads per block to the current-frame memory, and pulses next_block to the buffer. It waits for the block to settle on cur_out, then hands the block to the ME core with a start/done handshake before advancing.

---
 rtl/cur_fetch_ctrl.sv | 168 ++++++++++++++++
 tb/tb_cur_fetch_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cur_fetch_ctrl.sv
// rtl/cur_fetch_ctrl.sv - raster-order 8x8 current-block fetch scheduler; CUR_CTRL_STATS_EN adds stall/run counters
module cur_fetch_ctrl #(
    parameter  int FRAME_W  = 64,
    parameter  int FRAME_H  = 64,
    parameter  int ADDR_W   = 16,
    localparam int BLK_COLS = FRAME_W / 8,
    localparam int BLK_ROWS = FRAME_H / 8,
    localparam int BX_W     = (BLK_COLS > 1) ? $clog2(BLK_COLS) : 1,
    localparam int BY_W     = (BLK_ROWS > 1) ? $clog2(BLK_ROWS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_frame_start,
    input  logic [ADDR_W-1:0] i_frame_base,
    output logic              o_frame_busy,
    output logic              o_frame_done,
    output logic              o_mem_rd_en,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_next_block,
    input  logic              i_need_cur,
    output logic              o_me_start,
    input  logic              i_me_done,
    output logic [BX_W-1:0]   o_blk_x,
    output logic [BY_W-1:0]   o_blk_y
`ifdef CUR_CTRL_STATS_EN
    ,
    output logic [15:0]       o_stall_cnt,
    output logic [31:0]       o_run_cnt
`endif
);

    localparam logic [BX_W-1:0] BX_LAST = BX_W'(BLK_COLS - 1);
    localparam logic [BY_W-1:0] BY_LAST = BY_W'(BLK_ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [3:0]        r_beat;
    logic [ADDR_W-1:0] r_base;

    logic              w_wrap_x;
    logic              w_last_blk;
    logic [BX_W-1:0]   w_nx_x;
    logic [BY_W-1:0]   w_nx_y;
    logic              w_accept_done;

    // Even beat fetches pixels 0-3 of row beat>>1, odd beat pixels 4-7.
    function automatic logic [ADDR_W-1:0] f_addr(
        input logic [ADDR_W-1:0] base,
        input logic [BX_W-1:0]   bx,
        input logic [BY_W-1:0]   by,
        input logic [3:0]        beat
    );
        logic [ADDR_W-1:0] w_row;
        w_row = ADDR_W'(by) * ADDR_W'(8) + ADDR_W'(beat[3:1]);
        return base + w_row * ADDR_W'(FRAME_W / 4) + ADDR_W'(bx) * ADDR_W'(2) + ADDR_W'(beat[0]);
    endfunction

    always_comb begin
        w_wrap_x      = (o_blk_x == BX_LAST);
        w_last_blk    = w_wrap_x && (o_blk_y == BY_LAST);
        w_nx_x        = w_wrap_x ? '0 : o_blk_x + 1'b1;
        w_nx_y        = w_wrap_x ? o_blk_y + 1'b1 : o_blk_y;
        // A me_done coincident with me_start belongs to no block yet.
        w_accept_done = i_me_done && !o_me_start;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_beat       <= '0;
            r_base       <= '0;
            o_frame_busy <= 1'b0;
            o_frame_done <= 1'b0;
            o_mem_rd_en  <= 1'b0;
            o_mem_addr   <= '0;
            o_next_block <= 1'b0;
            o_me_start   <= 1'b0;
            o_blk_x      <= '0;
            o_blk_y      <= '0;
        end else begin
            o_next_block <= 1'b0;
            o_me_start   <= 1'b0;
            o_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_frame_start) begin
                        r_base       <= i_frame_base;
                        o_frame_busy <= 1'b1;
                        r_state      <= S_LOAD;
                        r_beat       <= '0;
                        o_blk_x      <= '0;
                        o_blk_y      <= '0;
                        o_mem_rd_en  <= 1'b1;
                        o_next_block <= 1'b1;
                        o_mem_addr   <= f_addr(i_frame_base, '0, '0, 4'd0);
                    end
                end
                S_LOAD: begin
                    if (r_beat == 4'd15) begin
                        r_state     <= S_SETTLE;
                        o_mem_rd_en <= 1'b0;
                    end else begin
                        r_beat     <= r_beat + 4'd1;
                        o_mem_addr <= f_addr(r_base, o_blk_x, o_blk_y, r_beat + 4'd1);
                    end
                end
                S_SETTLE: begin
                    if (!i_need_cur) begin
                        r_state    <= S_RUN;
                        o_me_start <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_accept_done) begin
                        if (w_last_blk) begin
                            r_state      <= S_DONE;
                            o_frame_done <= 1'b1;
                            o_frame_busy <= 1'b0;
                            o_blk_x      <= '0;
                            o_blk_y      <= '0;
                        end else begin
                            r_state      <= S_LOAD;
                            r_beat       <= '0;
                            o_blk_x      <= w_nx_x;
                            o_blk_y      <= w_nx_y;
                            o_mem_rd_en  <= 1'b1;
                            o_next_block <= 1'b1;
                            o_mem_addr   <= f_addr(r_base, w_nx_x, w_nx_y, 4'd0);
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CUR_CTRL_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_stall_cnt <= '0;
            o_run_cnt   <= '0;
        end else if (r_state == S_IDLE && i_frame_start) begin
            o_stall_cnt <= '0;
            o_run_cnt   <= '0;
        end else begin
            if (r_state == S_SETTLE && i_need_cur && o_stall_cnt != '1) begin
                o_stall_cnt <= o_stall_cnt + 16'd1;
            end
            if (r_state == S_RUN && o_run_cnt != '1) begin
                o_run_cnt <= o_run_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cur_fetch_ctrl.sv
// tb/tb_cur_fetch_ctrl.sv - directed self-checking bench for cur_fetch_ctrl on a 16x16 frame
module tb_cur_fetch_ctrl;

    localparam int FW = 16;
    localparam int FH = 16;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          frame_start;
    logic [AW-1:0] frame_base;
    logic          need_cur;
    logic          me_done;

    logic          frame_busy;
    logic          frame_done;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic          next_block;
    logic          me_start;
    logic [0:0]    blk_x;
    logic [0:0]    blk_y;
`ifdef CUR_CTRL_STATS_EN
    logic [15:0]   stall_cnt;
    logic [31:0]   run_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cur_fetch_ctrl #(
        .FRAME_W(FW),
        .FRAME_H(FH),
        .ADDR_W (AW)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_frame_start(frame_start),
        .i_frame_base (frame_base),
        .o_frame_busy (frame_busy),
        .o_frame_done (frame_done),
        .o_mem_rd_en  (mem_rd_en),
        .o_mem_addr   (mem_addr),
        .o_next_block (next_block),
        .i_need_cur   (need_cur),
        .o_me_start   (me_start),
        .i_me_done    (me_done),
        .o_blk_x      (blk_x),
        .o_blk_y      (blk_y)
`ifdef CUR_CTRL_STATS_EN
        ,
        .o_stall_cnt  (stall_cnt),
        .o_run_cnt    (run_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},  32'(frame_busy), 32'd0);
        chk({tag, "_done"},  32'(frame_done), 32'd0);
        chk({tag, "_rd_en"}, 32'(mem_rd_en),  32'd0);
        chk({tag, "_addr"},  32'(mem_addr),   32'd0);
        chk({tag, "_nb"},    32'(next_block), 32'd0);
        chk({tag, "_mes"},   32'(me_start),   32'd0);
        chk({tag, "_bx"},    32'(blk_x),      32'd0);
        chk({tag, "_by"},    32'(blk_y),      32'd0);
    endtask

    // Entered in the beat-0 cycle; leaves in the cycle after the accepted me_done.
    task automatic do_block(input int bx, input int by, input logic [AW-1:0] base,
                            input int stall, input bit ld_done, input bit run_fs,
                            input int abort_beat);
        logic [AW-1:0] ea;
        for (int b = 0; b < 16; b++) begin
            ea = base + AW'((by * 8 + b / 2) * (FW / 4) + bx * 2 + b % 2);
            if (b == abort_beat) begin
                rst_n = 1'b0;
                #1;
                chk_idle("abort");
                return;
            end
            chk($sformatf("addr b%0d (%0d,%0d)", b, bx, by), 32'(mem_addr), 32'(ea));
            chk($sformatf("rd_en b%0d", b), 32'(mem_rd_en), 32'd1);
            chk($sformatf("nb b%0d", b), 32'(next_block), 32'(b == 0));
            if (b == 0) begin
                chk("bx b0", 32'(blk_x), 32'(bx));
                chk("by b0", 32'(blk_y), 32'(by));
                chk("busy b0", 32'(frame_busy), 32'd1);
                chk("done b0", 32'(frame_done), 32'd0);
            end
            if (ld_done) me_done = (b == 4);
            if (b == 15) need_cur = (stall > 0);
            if (b < 15) tick();
        end
        tick();
        chk("settle rd_en", 32'(mem_rd_en), 32'd0);
        chk("settle mes", 32'(me_start), 32'd0);
        for (int s = 0; s < stall; s++) begin
            tick();
            chk($sformatf("stall mes s%0d", s), 32'(me_start), 32'd0);
        end
        need_cur = 1'b0;
        tick();
        chk("run mes", 32'(me_start), 32'd1);
        chk("run bx", 32'(blk_x), 32'(bx));
        chk("run by", 32'(blk_y), 32'(by));
        me_done = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            me_done     = 1'b0;
            frame_start = 1'b0;
            chk($sformatf("run mes k%0d", k), 32'(me_start), 32'd0);
            chk($sformatf("run nb k%0d", k), 32'(next_block), 32'd0);
            chk($sformatf("run bx k%0d", k), 32'(blk_x), 32'(bx));
            chk($sformatf("run by k%0d", k), 32'(blk_y), 32'(by));
            if (k == 2 && run_fs) begin
                frame_start = 1'b1;
                frame_base  = 16'h0800;
            end
            if (k == 5) me_done = 1'b1;
        end
        tick();
        me_done = 1'b0;
    endtask

    task automatic chk_frame_end(input string tag);
        chk({tag, " done"},  32'(frame_done), 32'd1);
        chk({tag, " busy"},  32'(frame_busy), 32'd0);
        chk({tag, " rd_en"}, 32'(mem_rd_en),  32'd0);
        chk({tag, " bx"},    32'(blk_x),      32'd0);
        chk({tag, " by"},    32'(blk_y),      32'd0);
        tick();
        chk({tag, " done+1"}, 32'(frame_done), 32'd0);
        chk({tag, " busy+1"}, 32'(frame_busy), 32'd0);
        chk({tag, " nb+1"},   32'(next_block), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        frame_start = 1'b0;
        frame_base  = '0;
        need_cur    = 1'b0;
        me_done     = 1'b0;
        repeat (3) tick();
        chk_idle("reset");
        rst_n = 1'b1;
        tick();
        chk_idle("post_reset");

        // Full frame at base 0 with ignored frame_start/me_done and one stalled settle.
        frame_base  = 16'h0000;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        do_block(0, 0, 16'h0000, 0, 1'b0, 1'b1, -1);
        do_block(1, 0, 16'h0000, 0, 1'b1, 1'b0, -1);
        do_block(0, 1, 16'h0000, 3, 1'b0, 1'b0, -1);
        do_block(1, 1, 16'h0000, 0, 1'b0, 1'b0, -1);
        chk_frame_end("frame1");
`ifdef CUR_CTRL_STATS_EN
        chk("stall_cnt f1", 32'(stall_cnt), 32'd3);
        chk("run_cnt f1", run_cnt, 32'd24);
`endif

        // Address wrap, then reset mid-LOAD.
        tick();
        frame_base  = 16'hFFFE;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        do_block(0, 0, 16'hFFFE, 0, 1'b0, 1'b0, 7);
        tick();
        chk_idle("in_reset");
        rst_n = 1'b1;
        tick();
        chk_idle("after_abort");
        tick();
        chk("after_abort done", 32'(frame_done), 32'd0);

        // Restart cleanly after the aborted frame.
        frame_base  = 16'h0100;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        do_block(0, 0, 16'h0100, 0, 1'b0, 1'b0, -1);
        do_block(1, 0, 16'h0100, 0, 1'b0, 1'b0, -1);
        do_block(0, 1, 16'h0100, 0, 1'b0, 1'b0, -1);
        do_block(1, 1, 16'h0100, 0, 1'b0, 1'b0, -1);
        chk_frame_end("frame3");
`ifdef CUR_CTRL_STATS_EN
        chk("stall_cnt f3", 32'(stall_cnt), 32'd0);
        chk("run_cnt f3", run_cnt, 32'd24);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
